// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path:
//               receiver state encoding, parity/data-width codes and a
//               helper that turns the data-width code into a bit count.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver frame-decoder states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Number of data bits (5..8) selected by the two-bit width code
  function automatic logic [3:0] data_bits(input logic [1:0] data_bit_num);
    logic [3:0] n;
    n = 4'd8;
    case (data_bit_num)
      DBITS_5: n = 4'd5;
      DBITS_6: n = 4'd6;
      DBITS_7: n = 4'd7;
      DBITS_8: n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for an asynchronous serial input.
//               Both flops reset to RESET_LEVEL so an idle-high line does
//               not look like a start bit coming out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_LEVEL;
      q    <= RESET_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : UART receiver. Mid-bit sampling of a synchronized rx line,
//               5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
//               Holding register with done pulse, error flags and rts_n
//               flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       rts_n
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_sync #(
    .RESET_LEVEL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_acc;
  logic [3:0]       nbits;
  logic             cfg_stop2;
  logic             cfg_par_en;
  logic             cfg_par_type;
  logic             second_stop;
  logic             pend_par;
  logic             pend_frame;

  logic half_tick;
  logic bit_tick;
  logic last_data;

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);
  assign last_data = ({1'b0, bit_idx} == (nbits - 4'd1));

  // Frame decoder, bit timer, holding register and flow control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_acc       <= 1'b0;
      nbits         <= 4'd8;
      cfg_stop2     <= 1'b0;
      cfg_par_en    <= 1'b0;
      cfg_par_type  <= 1'b0;
      second_stop   <= 1'b0;
      pend_par      <= 1'b0;
      pend_frame    <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
      rts_n         <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      // A read only matters while the holding register is full; a
      // completion later in this block overrides it.
      if (rx_read && rts_n) begin
        rts_n <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            nbits        <= data_bits(data_bit_num);
            cfg_stop2    <= stop_bit_num;
            cfg_par_en   <= parity_en;
            cfg_par_type <= parity_type;
            state        <= START;
          end
        end

        START: begin
          if (half_tick) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state       <= DATA;
              bit_idx     <= '0;
              shreg       <= '0;
              par_acc     <= 1'b0;
              pend_par    <= 1'b0;
              pend_frame  <= 1'b0;
              second_stop <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            par_acc        <= par_acc ^ rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (last_data) begin
              state <= cfg_par_en ? PARITY : STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_tick) begin
            cnt      <= '0;
            pend_par <= ((par_acc ^ rx_s) != cfg_par_type);
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (cfg_stop2 && !second_stop) begin
              second_stop <= 1'b1;
              if (!rx_s) begin
                pend_frame <= 1'b1;
              end
            end else begin
              // Leave mid-bit so a back-to-back start edge is not missed
              state         <= IDLE;
              rx_done       <= 1'b1;
              rx_data       <= shreg;
              parity_error  <= pend_par;
              frame_error   <= pend_frame | ~rx_s;
              overrun_error <= rts_n;
              rts_n         <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Scoreboard testbench for uart_rx_frame. Directed frames push
//               their hand-computed results into a queue; a monitor pops and
//               compares on every rx_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;
  logic       overrun_error;
  logic       rts_n;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_bit_num  (data_bit_num),
    .stop_bit_num  (stop_bit_num),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .rx_read       (rx_read),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .rts_n         (rts_n)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       oe;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_lat(input int act, input int req);
    checks++;
    if (act < req - 2 || act > req + 2) begin
      errors++;
      $display("FAIL latency: actual=%0d required=%0d+-2", act, req);
    end
  endtask

  // Monitor: pop and compare on each completion
  always @(negedge clk) begin
    if (!rst && rx_done === 1'b1) begin
      done_cnt++;
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        check("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
        check("overrun_error", {31'd0, overrun_error}, {31'd0, e.oe});
        check("rts_n_on_done", {31'd0, rts_n}, 32'd1);
        check_lat(cyc - e.t0, e.lat);
      end
    end
    prev_done = rx_done;
  end

  // Drive one frame; optionally post its expected result
  task automatic send(input logic [7:0] d, input int n, input bit pen, input bit ptype,
                      input bit pbad, input bit stop2, input bit sbad, input bit push,
                      input logic [7:0] xd, input logic xpe, input logic xfe, input logic xoe);
    exp_t x;
    logic pbit;
    pbit = ptype ^ pbad;
    for (int i = 0; i < n; i++) pbit = pbit ^ d[i];
    @(negedge clk);
    if (push) begin
      x.data = xd; x.pe = xpe; x.fe = xfe; x.oe = xoe; x.t0 = cyc;
      x.lat  = CPB * (n + (pen ? 1 : 0) + (stop2 ? 2 : 1)) + CPB / 2 + 1 + 2;
      sb.push_back(x);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (CPB) @(negedge clk);
    end
    rx = ~sbad;
    repeat (CPB) @(negedge clk);
    if (stop2) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] dbn, input logic s2, input logic pen, input logic pt);
    @(negedge clk);
    data_bit_num = dbn; stop_bit_num = s2; parity_en = pen; parity_type = pt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    rst = 1'b1; rx = 1'b1; rx_read = 1'b0;
    data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0; parity_type = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_flags", {28'd0, rx_done, parity_error, frame_error, overrun_error}, 32'd0);
    check("reset_rts_n", {31'd0, rts_n}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: 8N1 0xA5, then read releases rts_n
    send(8'hA5, 8, 0, 0, 0, 0, 0, 1, 8'hA5, 0, 0, 0);
    check("t1_rts_full", {31'd0, rts_n}, 32'd1);
    read_pulse();
    check("t1_rts_free", {31'd0, rts_n}, 32'd0);

    // 2: 7E2, bad parity then good
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send(8'h55, 7, 1, 0, 1, 1, 0, 1, 8'h55, 1, 0, 0);
    read_pulse();
    send(8'h2A, 7, 1, 0, 0, 1, 0, 1, 8'h2A, 0, 0, 0);
    read_pulse();

    // 3: 8N1 with stop bit low
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 8, 0, 0, 0, 0, 1, 1, 8'h3C, 0, 1, 0);
    read_pulse();

    // 4: overrun then recovery
    send(8'h11, 8, 0, 0, 0, 0, 0, 1, 8'h11, 0, 0, 0);
    send(8'h22, 8, 0, 0, 0, 0, 0, 1, 8'h22, 0, 0, 1);
    read_pulse();
    send(8'h33, 8, 0, 0, 0, 0, 0, 1, 8'h33, 0, 0, 0);
    read_pulse();
    check("t4_overrun_held", {31'd0, overrun_error}, 32'd0);

    // 5: short low glitch in idle
    snap = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t5_no_done", done_cnt, snap);
    check("t5_data_kept", {24'd0, rx_data}, 32'h33);
    check("t5_rts_n", {31'd0, rts_n}, 32'd0);

    // 6: reset in the middle of 0xFF, then clean 0x81
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("t6_reset_flags", {28'd0, rx_done, parity_error, frame_error, overrun_error}, 32'd0);
    check("t6_reset_rts_n", {31'd0, rts_n}, 32'd0);
    rst = 1'b0;
    repeat (6 * CPB) @(negedge clk);
    check("t6_no_done", done_cnt, snap);
    send(8'h81, 8, 0, 0, 0, 0, 0, 1, 8'h81, 0, 0, 0);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("done_count", done_cnt, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
